// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues sequential word requests to instruction memory, buffers
// in-order responses in a prefetch queue and discards responses made stale by a redirect.
module fetch_queue #(
  parameter int unsigned     PC_W     = 30,
  parameter int unsigned     DATA_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [PC_W+DATA_W-1:0] if_id_bus
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + DATA_W;
  localparam logic [CW:0] QdepthC = (CW+1)'(QDEPTH);

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [EW-1:0]   r_mem [QDEPTH];

  logic [CW:0]     w_inflight;
  logic            w_grant;
  logic            w_rsp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_next;

  always_comb begin
    // Credits cover both queued entries and in-flight requests, so the queue never overflows.
    w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
    imem_req   = !reset && !redirect_valid && (w_inflight < QdepthC);
    imem_addr  = reset ? RESET_PC : r_fetch_pc;
    w_grant    = imem_req && imem_gnt;
    // A response with nothing outstanding is spurious and ignored entirely.
    w_rsp      = imem_rvalid && (r_outstanding != '0);
    w_drop     = w_rsp && ((r_drop_cnt != '0) || redirect_valid);
    w_push     = w_rsp && !w_drop;
    id_valid   = !reset && !redirect_valid && (r_count != '0);
    w_pop      = id_valid && id_ready;
    if_id_bus  = r_mem[r_rptr];
  end

  always_comb begin
    case ({w_grant, w_rsp})
      2'b10:   w_out_next = r_outstanding + CW'(1);
      2'b01:   w_out_next = r_outstanding - CW'(1);
      default: w_out_next = r_outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        // Pending drops are a subset of outstanding, so every request still in flight
        // after this cycle is stale; no grant can happen here.
        r_drop_cnt <= w_out_next;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + PC_W'(1);
        if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + PC_W'(1);
          r_wptr   <= r_wptr + AW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_rsp_pc, imem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency-configurable memory model, expected-instruction scoreboard,
// a per-cycle vector table for the stall scenario and hand sequences for redirect/reset/wrap.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [61:0] if_id_bus;

  logic        req2;
  logic [3:0]  addr2;
  logic        rv2;
  logic [31:0] rd2;
  logic        valid2;
  logic [35:0] bus2;

  int checks = 0;
  int failures = 0;

  logic        m_rv;
  logic [31:0] m_data;
  logic        inj_rv;
  int          lat;
  int          cyc = 0;
  logic [29:0] mq_addr[$];
  int          mq_due[$];
  logic [61:0] sb[$];
  logic [29:0] exp_addr;

  assign imem_rvalid = m_rv | inj_rv;
  assign imem_rdata  = m_data;

  fetch_queue dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_ready(id_ready), .if_id_bus(if_id_bus)
  );

  fetch_queue #(.PC_W(4), .DATA_W(32), .RESET_PC(4'hE), .QDEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rv2), .imem_rdata(rd2), .redirect_valid(1'b0), .redirect_pc(4'h0),
    .id_valid(valid2), .id_ready(1'b1), .if_id_bus(bus2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'h9E37_79B9 * {2'b00, a} + 32'h0000_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory response driver: in-order, fixed latency, reset together with the DUT.
  initial begin
    m_rv = 0;
    m_data = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        m_rv = 1;
        m_data = mem_word(mq_addr[0]);
      end else begin
        m_rv = 0;
        m_data = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard and memory request capture, sampled mid-cycle.
  initial begin
    exp_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        mq_addr.delete();
        mq_due.delete();
        exp_addr = '0;
      end else begin
        if (imem_req) chk("req_addr", {34'd0, imem_addr}, {34'd0, exp_addr});
        if (id_valid && id_ready) begin
          if (sb.size() == 0) chk("sb_unexpected_output", {2'b0, if_id_bus}, 64'd0);
          else chk("sb_data", {2'b0, if_id_bus}, {2'b0, sb.pop_front()});
        end
        if (redirect_valid) begin
          sb.delete();
          exp_addr = redirect_pc;
        end else if (imem_req && imem_gnt) begin
          sb.push_back({exp_addr, mem_word(exp_addr)});
          exp_addr = exp_addr + 30'd1;
        end
        if (m_rv && mq_addr.size() > 0) begin
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
          mq_addr.push_back(imem_addr);
          mq_due.push_back(cyc + lat);
        end
      end
    end
  end

  // Single-cycle memory for the narrow-PC instance.
  initial begin
    logic       g2;
    logic [3:0] a2;
    rv2 = 0;
    rd2 = '0;
    forever begin
      @(negedge clk);
      g2 = req2;
      a2 = addr2;
      @(posedge clk);
      #2;
      rv2 = g2 && !reset;
      rd2 = mem_word({26'd0, a2});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  typedef struct {
    logic        rdy;
    logic        req;
    logic [29:0] addr;
    logic        valid;
    logic [29:0] pc;
  } vec_t;

  vec_t vec [16];

  initial begin
    int   found;
    int   waited;
    logic [29:0] pc;
    logic [3:0]  e4;

    // Stall from reset with a 1-cycle memory: four grants fill the credits, then release.
    vec[0]  = '{1'b0, 1'b1, 30'd0, 1'b0, 30'd0};
    vec[1]  = '{1'b0, 1'b1, 30'd1, 1'b0, 30'd0};
    vec[2]  = '{1'b0, 1'b1, 30'd2, 1'b1, 30'd0};
    vec[3]  = '{1'b0, 1'b1, 30'd3, 1'b1, 30'd0};
    vec[4]  = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0};
    vec[5]  = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0};
    vec[6]  = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0};
    vec[7]  = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0};
    vec[8]  = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0};
    vec[9]  = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0};
    vec[10] = '{1'b1, 1'b0, 30'd4, 1'b1, 30'd0};
    vec[11] = '{1'b1, 1'b1, 30'd4, 1'b1, 30'd1};
    vec[12] = '{1'b1, 1'b1, 30'd5, 1'b1, 30'd2};
    vec[13] = '{1'b1, 1'b1, 30'd6, 1'b1, 30'd3};
    vec[14] = '{1'b1, 1'b1, 30'd7, 1'b1, 30'd4};
    vec[15] = '{1'b1, 1'b1, 30'd8, 1'b1, 30'd5};

    reset = 1; id_ready = 0; imem_gnt = 1; redirect_valid = 0; redirect_pc = '0;
    inj_rv = 0; lat = 1;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_addr", {34'd0, imem_addr}, 64'd0);
    next_cycle();
    reset = 0;

    for (int i = 0; i < 16; i++) begin
      id_ready = vec[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i + 1), {63'd0, imem_req}, {63'd0, vec[i].req});
      chk($sformatf("vec%0d_addr", i + 1), {34'd0, imem_addr}, {34'd0, vec[i].addr});
      chk($sformatf("vec%0d_valid", i + 1), {63'd0, id_valid}, {63'd0, vec[i].valid});
      if (vec[i].valid) begin
        chk($sformatf("vec%0d_pc", i + 1), {34'd0, if_id_bus[61:32]}, {34'd0, vec[i].pc});
        chk($sformatf("vec%0d_instr", i + 1), {32'd0, if_id_bus[31:0]},
            {32'd0, mem_word(vec[i].pc)});
      end
      next_cycle();
    end

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("thruput", {63'd0, id_valid}, 64'd1);
      next_cycle();
    end

    // Fill the queue, then reset mid-stream and inject a stray response.
    id_ready = 0;
    repeat (8) next_cycle();
    @(negedge clk);
    chk("full_req", {63'd0, imem_req}, 64'd0);
    chk("full_valid", {63'd0, id_valid}, 64'd1);
    next_cycle();
    reset = 1;
    @(negedge clk);
    chk("rst2_req", {63'd0, imem_req}, 64'd0);
    chk("rst2_valid", {63'd0, id_valid}, 64'd0);
    chk("rst2_addr", {34'd0, imem_addr}, 64'd0);
    next_cycle();
    reset = 0; imem_gnt = 0; inj_rv = 1; id_ready = 1;
    @(negedge clk);
    chk("post_rst_valid", {63'd0, id_valid}, 64'd0);
    chk("post_rst_addr", {34'd0, imem_addr}, 64'd0);
    chk("post_rst_req", {63'd0, imem_req}, 64'd1);
    next_cycle();
    inj_rv = 0; imem_gnt = 1;
    @(negedge clk);
    chk("stale_ignored", {63'd0, id_valid}, 64'd0);
    chk("stale_req", {63'd0, imem_req}, 64'd1);
    next_cycle();
    @(negedge clk);
    chk("first_lat", {63'd0, id_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("first_valid", {63'd0, id_valid}, 64'd1);
    chk("first_pc", {34'd0, if_id_bus[61:32]}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      chk("thruput2", {63'd0, id_valid}, 64'd1);
    end
    next_cycle();

    // Redirect with three requests in flight on a 3-cycle memory.
    reset = 1; lat = 3;
    next_cycle();
    reset = 0;
    repeat (3) next_cycle();
    redirect_valid = 1; redirect_pc = 30'h100;
    @(negedge clk);
    chk("redir_req", {63'd0, imem_req}, 64'd0);
    chk("redir_valid", {63'd0, id_valid}, 64'd0);
    next_cycle();
    redirect_valid = 0;
    @(negedge clk);
    chk("redir_addr", {34'd0, imem_addr}, 64'h100);
    chk("redir_req1", {63'd0, imem_req}, 64'd1);
    next_cycle();
    found = 0; waited = 0;
    while (!found && waited < 20) begin
      @(negedge clk);
      if (id_valid) found = 1;
      else begin
        waited++;
        next_cycle();
      end
    end
    chk("redir_found", 64'(found), 64'd1);
    chk("redir_lat", 64'(waited), 64'd3);
    if (found) begin
      chk("redir_pc", {34'd0, if_id_bus[61:32]}, 64'h100);
      chk("redir_instr", {32'd0, if_id_bus[31:0]}, {32'd0, mem_word(30'h100)});
    end
    next_cycle();

    // Redirect coinciding with a response, then a second redirect the next cycle.
    reset = 1; lat = 1;
    next_cycle();
    reset = 0;
    repeat (4) next_cycle();
    redirect_valid = 1; redirect_pc = 30'h200;
    @(negedge clk);
    chk("r1_valid", {63'd0, id_valid}, 64'd0);
    next_cycle();
    redirect_pc = 30'h300;
    @(negedge clk);
    chk("r2_req", {63'd0, imem_req}, 64'd0);
    next_cycle();
    redirect_valid = 0;
    @(negedge clk);
    chk("r2_addr", {34'd0, imem_addr}, 64'h300);
    chk("r2_req1", {63'd0, imem_req}, 64'd1);
    chk("r2_valid_n1", {63'd0, id_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("r2_valid_n2", {63'd0, id_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("r2_valid_n3", {63'd0, id_valid}, 64'd1);
    chk("r2_pc", {34'd0, if_id_bus[61:32]}, 64'h300);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clk);
      if (id_valid) begin
        pc = if_id_bus[61:32];
        chk("tgt2_only", {63'd0, (pc >= 30'h300) && (pc < 30'h310)}, 64'd1);
      end
    end
    next_cycle();

    // Narrow PC instance: fetch from 0xE wraps through 0.
    reset = 1;
    repeat (2) next_cycle();
    reset = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        e4 = 4'(14 + k - 1);
        chk($sformatf("wrap_addr%0d", k), {60'd0, addr2}, {60'd0, e4});
        chk($sformatf("wrap_req%0d", k), {63'd0, req2}, 64'd1);
      end
      if (k >= 3) begin
        e4 = 4'(14 + k - 3);
        chk($sformatf("wrap_valid%0d", k), {63'd0, valid2}, 64'd1);
        chk($sformatf("wrap_pc%0d", k), {60'd0, bus2[35:32]}, {60'd0, e4});
        chk($sformatf("wrap_instr%0d", k), {32'd0, bus2[31:0]},
            {32'd0, mem_word({26'd0, e4})});
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
